// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Decodes ALU control, runs the ALU, computes the branch target and the
// destination register, and registers everything into the EX/MEM boundary.
// Optional feature macro EX_MULDIV_EN: adds the iterative 32-step MULTU
// multiplier, the HI/LO registers and the IDLE/BUSY/DONE stall FSM. Without
// it MULTU/MFHI/MFLO return 0 in one cycle and stall is tied low.

// Protocol checker: flush never coexists with stall, and a stalled cycle
// always emits a bubble into EX/MEM.
module ex_stage_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  input logic       stall,
  input logic [1:0] wb_ctlout,
  input logic [2:0] m_ctlout
);

  a_flush_no_stall : assert property (@(posedge clk) disable iff (!rst_n)
    flush |-> !stall);

  a_stall_bubble : assert property (@(posedge clk) disable iff (!rst_n)
    stall |=> (wb_ctlout == 2'd0 && m_ctlout == 3'd0));

endmodule

module ex_stage
`ifdef EX_MULDIV_EN
#(
  parameter int MUL_CYCLES = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic        stall,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  dest_reg
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_MULTU = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_NONE  = 4'd8
  } alu_op_e;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  alu_op_e     op_s;
  logic [31:0] opb_s;
  logic [31:0] alu_res_s;
  logic [31:0] br_target_s;
  logic [4:0]  dest_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic        bubble_s;
  logic        stall_s;

  assign opb_s       = alusrc ? s_extend : rdata2;
  assign br_target_s = npc + {s_extend[29:0], 2'b00};
  assign dest_s      = regdst ? instr_1511 : instr_2016;

  // ALU control decode from aluop and the funct field
  always_comb begin
    op_s = OP_NONE;
    case (aluop)
      2'b00, 2'b11: op_s = OP_ADD;
      2'b01:        op_s = OP_SUB;
      2'b10: begin
        case (s_extend[5:0])
          FN_ADD:   op_s = OP_ADD;
          FN_SUB:   op_s = OP_SUB;
          FN_AND:   op_s = OP_AND;
          FN_OR:    op_s = OP_OR;
          FN_SLT:   op_s = OP_SLT;
          FN_MULTU: op_s = OP_MULTU;
          FN_MFHI:  op_s = OP_MFHI;
          FN_MFLO:  op_s = OP_MFLO;
          default:  op_s = OP_NONE;
        endcase
      end
      default: op_s = OP_NONE;
    endcase
  end

  // ALU: MULTU retires with LO; HI/LO read as 0 when the multiplier is absent
  always_comb begin
    alu_res_s = 32'd0;
    case (op_s)
      OP_ADD:   alu_res_s = rdata1 + opb_s;
      OP_SUB:   alu_res_s = rdata1 - opb_s;
      OP_AND:   alu_res_s = rdata1 & opb_s;
      OP_OR:    alu_res_s = rdata1 | opb_s;
      OP_SLT:   alu_res_s = ($signed(rdata1) < $signed(opb_s)) ? 32'd1 : 32'd0;
      OP_MULTU: alu_res_s = lo_s;
      OP_MFHI:  alu_res_s = hi_s;
      OP_MFLO:  alu_res_s = lo_s;
      default:  alu_res_s = 32'd0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  state_e        state_r;
  state_e        state_s;
  logic [CW-1:0] cnt_r;
  logic [63:0]   mcand_r;
  logic [63:0]   acc_r;
  logic [63:0]   acc_s;
  logic [31:0]   mplier_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic          is_mul_s;

  assign is_mul_s = (op_s == OP_MULTU);
  assign acc_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign hi_s     = hi_r;
  assign lo_s     = lo_r;

  // Next-state, stall and bubble decision; flush overrides everything
  always_comb begin
    state_s  = state_r;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    if (flush) begin
      state_s  = ST_IDLE;
      stall_s  = 1'b0;
      bubble_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            state_s  = ST_BUSY;
            stall_s  = 1'b1;
            bubble_s = 1'b1;
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_BUSY: begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_BUSY;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift-add multiplier datapath; HI/LO written on the final step only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      mcand_r  <= 64'd0;
      acc_r    <= 64'd0;
      mplier_r <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else if (flush) begin
      cnt_r    <= '0;
    end else if (state_r == ST_IDLE && is_mul_s) begin
      cnt_r    <= '0;
      acc_r    <= 64'd0;
      mcand_r  <= {32'd0, rdata1};
      mplier_r <= rdata2;
    end else if (state_r == ST_BUSY) begin
      acc_r    <= acc_s;
      mcand_r  <= {mcand_r[62:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[31:1]};
      cnt_r    <= cnt_r + CW'(1);
      if (cnt_r == LAST_CNT) begin
        hi_r <= acc_s[63:32];
        lo_r <= acc_s[31:0];
      end
    end
  end
`else
  assign hi_s     = 32'd0;
  assign lo_s     = 32'd0;
  assign stall_s  = 1'b0;
  assign bubble_s = flush;
`endif

  assign stall = stall_s & rst_n;

  // EX/MEM boundary register: bubble clears control and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout  <= 2'd0;
      m_ctlout   <= 3'd0;
      add_result <= 32'd0;
      zero       <= 1'b0;
      alu_result <= 32'd0;
      rdata2out  <= 32'd0;
      dest_reg   <= 5'd0;
    end else if (bubble_s) begin
      wb_ctlout  <= 2'd0;
      m_ctlout   <= 3'd0;
      add_result <= 32'd0;
      zero       <= 1'b0;
      alu_result <= 32'd0;
      rdata2out  <= 32'd0;
      dest_reg   <= 5'd0;
    end else begin
      wb_ctlout  <= wb_ctl;
      m_ctlout   <= m_ctl;
      add_result <= br_target_s;
      zero       <= (alu_res_s == 32'd0);
      alu_result <= alu_res_s;
      rdata2out  <= rdata2;
      dest_reg   <= dest_s;
    end
  end

  ex_stage_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall     (stall),
    .wb_ctlout (wb_ctlout),
    .m_ctlout  (m_ctlout)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a cycle-level model derived from the
// instruction semantics plus hand-computed literal checks.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MUL_N = 32;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;
  logic        stall;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  dest_reg;

  int checks = 0;
  int errors = 0;

  // model state
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [31:0] e_add;
  logic        e_zero;
  logic [31:0] e_alu;
  logic [31:0] e_rd2;
  logic [4:0]  e_dest;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] prod;
  int          busy_left;
  bit          done_f;
  logic        last_stall;
  int          stall_cnt;

  ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wb_ctl     (wb_ctl),
    .m_ctl      (m_ctl),
    .regdst     (regdst),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .npc        (npc),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .s_extend   (s_extend),
    .instr_2016 (instr_2016),
    .instr_1511 (instr_1511),
    .stall      (stall),
    .wb_ctlout  (wb_ctlout),
    .m_ctlout   (m_ctlout),
    .add_result (add_result),
    .zero       (zero),
    .alu_result (alu_result),
    .rdata2out  (rdata2out),
    .dest_reg   (dest_reg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_multu();
    return MUL_EN && aluop == 2'b10 && s_extend[5:0] == 6'b011001;
  endfunction

  function automatic logic [31:0] model_alu();
    logic [31:0] b;
    b = alusrc ? s_extend : rdata2;
    if (aluop == 2'b01) return rdata1 - b;
    if (aluop != 2'b10) return rdata1 + b;
    case (s_extend[5:0])
      6'b100000: return rdata1 + b;
      6'b100010: return rdata1 - b;
      6'b100100: return rdata1 & b;
      6'b100101: return rdata1 | b;
      6'b101010: return ($signed(rdata1) < $signed(b)) ? 32'd1 : 32'd0;
      6'b011001: return MUL_EN ? m_lo : 32'd0;
      6'b010000: return MUL_EN ? m_hi : 32'd0;
      6'b010010: return MUL_EN ? m_lo : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    e_wb = 2'd0; e_m = 3'd0; e_add = 32'd0; e_zero = 1'b0;
    e_alu = 32'd0; e_rd2 = 32'd0; e_dest = 5'd0;
    m_hi = 32'd0; m_lo = 32'd0; prod = 64'd0;
    busy_left = 0; done_f = 1'b0;
  endtask

  task automatic model_bubble();
    e_wb = 2'd0; e_m = 3'd0; e_add = 32'd0; e_zero = 1'b0;
    e_alu = 32'd0; e_rd2 = 32'd0; e_dest = 5'd0;
  endtask

  task automatic model_capture();
    e_wb   = wb_ctl;
    e_m    = m_ctl;
    e_add  = npc + s_extend * 32'd4;
    e_alu  = model_alu();
    e_zero = (e_alu == 32'd0);
    e_rd2  = rdata2;
    e_dest = regdst ? instr_1511 : instr_2016;
  endtask

  // what the EX/MEM boundary must hold after the coming rising edge
  task automatic model_edge();
    if (flush) begin
      busy_left = 0; done_f = 1'b0; model_bubble();
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_hi = prod[63:32]; m_lo = prod[31:0]; done_f = 1'b1;
      end
      model_bubble();
    end else if (done_f) begin
      done_f = 1'b0; model_capture();
    end else if (is_multu()) begin
      busy_left = MUL_N;
      prod = {32'd0, rdata1} * {32'd0, rdata2};
      model_bubble();
    end else begin
      model_capture();
    end
  endtask

  // one cycle: compare at the falling edge, advance the model, return after the rise
  task automatic step();
    logic exp_stall;
    @(negedge clk);
    exp_stall = MUL_EN && !flush && (busy_left > 0 || (!done_f && is_multu()));
    chk("stall", stall, exp_stall);
    chk("wb_ctlout", wb_ctlout, e_wb);
    chk("m_ctlout", m_ctlout, e_m);
    chk("add_result", add_result, e_add);
    chk("zero", zero, e_zero);
    chk("alu_result", alu_result, e_alu);
    chk("rdata2out", rdata2out, e_rd2);
    chk("dest_reg", dest_reg, e_dest);
    last_stall = stall;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic rdst,
                       input logic asrc, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic [4:0] rt, input logic [4:0] rd);
    wb_ctl = wb; m_ctl = m; regdst = rdst; alusrc = asrc; aluop = op; npc = pc4;
    rdata1 = a; rdata2 = b; s_extend = se; instr_2016 = rt; instr_1511 = rd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_wb"}, wb_ctlout, 2'd0);
    chk({tag, "_m"}, m_ctlout, 3'd0);
    chk({tag, "_add"}, add_result, 32'd0);
    chk({tag, "_zero"}, zero, 1'b0);
    chk({tag, "_alu"}, alu_result, 32'd0);
    chk({tag, "_rd2"}, rdata2out, 32'd0);
    chk({tag, "_dest"}, dest_reg, 5'd0);
  endtask

  // run a MULTU held on the inputs until stall drops, counting stalled cycles
  task automatic run_multu(input logic [31:0] a, input logic [31:0] b);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h200, a, b, 32'h0000_0019, 5'd0, 5'd0);
    stall_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_stall) stall_cnt++;
      else break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    model_reset();
    drive(2'b11, 3'b111, 1'b1, 1'b0, 2'b10, 32'h4, 32'h3, 32'h4, 32'h0000_0019, 5'd1, 5'd2);
    #1;
    check_all_zero("reset");
    drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // R-type sub 5-5
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h100, 32'd5, 32'd5, 32'h0000_0022, 5'd3, 5'd9);
    step();
    chk("sub_alu", alu_result, 32'd0);
    chk("sub_zero", zero, 1'b1);
    chk("sub_dest", dest_reg, 5'd9);

    // immediate add and branch target
    drive(2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h100, 32'h10, 32'h55, 32'hFFFF_FFFC, 5'd7, 5'd12);
    step();
    chk("addi_alu", alu_result, 32'h0000_000C);
    chk("addi_target", add_result, 32'h0000_00F0);
    chk("addi_dest", dest_reg, 5'd7);

    // signed slt
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h104, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 5'd4, 5'd5);
    step();
    chk("slt_alu", alu_result, 32'd1);

    // further ALU patterns
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h108, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0024, 5'd1, 5'd2);
    step();
    chk("and_alu", alu_result, 32'h0000_F000);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h10C, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0025, 5'd1, 5'd3);
    step();
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h110, 32'h7FFF_FFFF, 32'd1, 32'h0000_0020, 5'd1, 5'd4);
    step();
    chk("add_wrap", alu_result, 32'h8000_0000);
    drive(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h114, 32'd0, 32'd1, 32'h0000_0010, 5'd6, 5'd0);
    step();
    chk("sub_wrap", alu_result, 32'hFFFF_FFFF);
    chk("beq_target", add_result, 32'h0000_0154);
    drive(2'b01, 3'b001, 1'b1, 1'b0, 2'b10, 32'h118, 32'h1234, 32'h5678, 32'h0000_0000, 5'd8, 5'd10);
    step();
    chk("bad_funct", alu_result, 32'd0);
    drive(2'b00, 3'b010, 1'b0, 1'b1, 2'b11, 32'h11C, 32'h0000_1000, 32'h0, 32'h0000_0020, 5'd11, 5'd0);
    step();
    chk("aluop11_add", alu_result, 32'h0000_1020);

    // MULTU 0xFFFFFFFF * 2, then MFHI / MFLO
    run_multu(32'hFFFF_FFFF, 32'd2);
    chk("multu_stall_len", stall_cnt, MUL_EN ? 33 : 0);
    chk("multu_lo", alu_result, MUL_EN ? 32'hFFFF_FFFE : 32'h0);
    chk("multu_wb", wb_ctlout, 2'b10);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h204, 32'h0, 32'h0, 32'h0000_0010, 5'd0, 5'd13);
    step();
    chk("mfhi", alu_result, MUL_EN ? 32'd1 : 32'd0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h208, 32'h0, 32'h0, 32'h0000_0012, 5'd0, 5'd14);
    step();
    chk("mflo", alu_result, MUL_EN ? 32'hFFFF_FFFE : 32'h0);

    // flush at iteration 10 aborts, HI/LO keep their old values
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h20C, 32'd3, 32'd5, 32'h0000_0019, 5'd0, 5'd15);
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wb", wb_ctlout, 2'd0);
    chk("flush_m", m_ctlout, 3'd0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h210, 32'h0, 32'h0, 32'h0000_0012, 5'd0, 5'd16);
    step();
    chk("flush_stall", stall, 1'b0);
    chk("flush_lo_kept", alu_result, MUL_EN ? 32'hFFFF_FFFE : 32'h0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h214, 32'h0, 32'h0, 32'h0000_0010, 5'd0, 5'd17);
    step();
    chk("flush_hi_kept", alu_result, MUL_EN ? 32'd1 : 32'd0);

    // second full multiply
    run_multu(32'h1234_5678, 32'h0000_0010);
    chk("multu2_stall_len", stall_cnt, MUL_EN ? 33 : 0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h218, 32'h0, 32'h0, 32'h0000_0010, 5'd0, 5'd18);
    step();
    chk("mfhi2", alu_result, MUL_EN ? 32'd1 : 32'd0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h21C, 32'h0, 32'h0, 32'h0000_0012, 5'd0, 5'd19);
    step();
    chk("mflo2", alu_result, MUL_EN ? 32'h2345_6780 : 32'h0);

    // reset in the middle of a multiply
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h220, 32'd7, 32'd9, 32'h0000_0019, 5'd0, 5'd20);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h224, 32'h0, 32'h0, 32'h0000_0010, 5'd0, 5'd21);
    step();
    chk("mfhi_after_reset", alu_result, 32'd0);
    chk("mfhi_after_reset_dest", dest_reg, 5'd21);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
